decoding_stage: RTL and testbench
=================================

Name: decoding_stage

Overview:
- Combined decode and execute stage of the 16-bit pipelined processor.
- Holds an 8x16 general register file with one external write port (fed by write-back).
- Decodes a 16-bit instruction, reads up to two source registers, and performs one ALU operation.
- Registers the ALU output as the stage result for the next pipeline stage.

Parameters:
- None. Data width is fixed at 16 bits and register count at 8 (3-bit addresses).

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears register file and result
- write_addr  input  3  register file write address (R0..R7)
- write_data  input  16  register file write data
- instruction  input  16  instruction to decode and execute this cycle
- write_en  input  1  register file write enable, active-high
- result  output  16  registered ALU result

Behaviour:
- Reset: asynchronous and active-high. While reset=1, all 8 registers = 0x0000 and result = 0x0000, independent of clk. Assertion mid-operation clears state immediately. First capture happens on the first rising clk edge after reset deasserts.
- Instruction fields:
  - opcode = instruction[15:11]
  - rs1 = instruction[10:8]
  - rs2 = instruction[7:5]
  - imm = instruction[4:0]
  - shift amount = imm[3:0]; imm[4] is ignored.
- Register read: combinational, two read ports (rs1 → A, rs2 → B).
- Write bypass: if write_en=1 and write_addr equals a source address, that operand takes write_data in the same cycle. This applies independently to A and B.
- Register write: on rising clk with write_en=1, reg[write_addr] <= write_data. R0 is an ordinary writable register. Writes with write_en=0 are ignored.
- Opcodes (ALU output F, all arithmetic modulo 2^16, carries discarded):
  - 00000 NOP: F = 0x0000
  - 00001 NOT: F = ~A
  - 00010 INC: F = A + 1
  - 00011 DEC: F = A - 1
  - 00100 MOV: F = A
  - 00101 ADD: F = A + B
  - 00110 SUB: F = A - B
  - 00111 AND: F = A & B
  - 01000 OR: F = A | B
  - 01001 XOR: F = A ^ B
  - 01100 SHL: F = A << shamt, zero fill
  - 01101 SHR: F = A >> shamt, logical, zero fill
  - 01110 LDI: F = zero-extended imm
  - all other opcodes: F = 0x0000
- Result register: result <= F on every rising clk edge when not in reset. Latency is one cycle: an instruction present before edge N appears on result after edge N.
- No stall or enable. instruction is sampled every cycle. An X or undriven instruction produces an undefined result; no error is flagged.
- The stage never writes its own result back into the register file. All register writes come only through write_addr, write_data and write_en.
- Boundary cases:
  - INC 0xFFFF → 0x0000
  - DEC 0x0000 → 0xFFFF
  - SUB with B > A wraps
  - shamt 0 passes A unchanged
  - shamt 15 keeps one bit
  - rs1 == rs2 is legal; both ports read the same value.

Test Plan:
- Reset, then instruction 0x65BF (SHL, rs1=R5, shamt=15) with write_en=0 → result 0x0000 after the next edge. 0x25BF (MOV R5) → result 0x0000.
- write_en=1, write_addr=5, write_data=0x0001 for one edge, then SHL R5 by 15 (0x65BF) → result 0x8000. MOV R5 (0x25BF) → 0x0001.
- Write R1=0x7FFF and R2=0x0001, then ADD rs1=R1, rs2=R2 (0x2940) → 0x8000. SUB (0x3140) → 0x7FFE. SUB rs1=R2, rs2=R1 (0x3220) → 0x8002.
- Bypass: write_en=1, write_addr=3, write_data=0x00F0 in the same cycle as MOV R3 (0x2300) → result 0x00F0 after that edge. R3 also reads 0x00F0 on later cycles.
- Wrap and shift: R4=0xFFFF; INC R4 (0x1400) → 0x0000. SHR R4 by 4 (0x6C04) → 0x0FFF. NOT R4 (0x0C00) → 0x0000. LDI imm=0x1F (0x701F) → 0x001F.
- Async reset mid-run: with result=0x8000, assert reset between edges → result 0x0000 immediately and all registers read 0. Unused opcode 0x7800 → 0x0000.

Source files
------------

// File: rtl/decoding_stage.sv
// Decode/execute stage of the 16-bit pipeline: 8x16 register file with a
// write-back port, two bypassed read ports, one ALU op and a registered result.
module decoding_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  write_addr,
  input  logic [15:0] write_data,
  input  logic [15:0] instruction,
  input  logic        write_en,
  output logic [15:0] result
);

  localparam int DATA_W = 16;
  localparam int REGS   = 8;

  typedef enum logic [4:0] {
    OP_NOP = 5'b00000,
    OP_NOT = 5'b00001,
    OP_INC = 5'b00010,
    OP_DEC = 5'b00011,
    OP_MOV = 5'b00100,
    OP_ADD = 5'b00101,
    OP_SUB = 5'b00110,
    OP_AND = 5'b00111,
    OP_OR  = 5'b01000,
    OP_XOR = 5'b01001,
    OP_SHL = 5'b01100,
    OP_SHR = 5'b01101,
    OP_LDI = 5'b01110
  } opcode_e;

  // Arithmetic is modulo 2^16; shifts are logical with zero fill.
  function automatic logic [DATA_W-1:0] alu(input logic [4:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [4:0]        imm);
    logic [DATA_W-1:0] f;
    f = '0;
    case (op)
      OP_NOT:  f = ~a;
      OP_INC:  f = a + 16'd1;
      OP_DEC:  f = a - 16'd1;
      OP_MOV:  f = a;
      OP_ADD:  f = a + b;
      OP_SUB:  f = a - b;
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_SHL:  f = a << imm[3:0];
      OP_SHR:  f = a >> imm[3:0];
      OP_LDI:  f = {11'd0, imm};
      default: f = '0;
    endcase
    return f;
  endfunction

  logic [DATA_W-1:0] regs [REGS];
  logic [4:0]        opcode_p0;
  logic [2:0]        rs1_p0;
  logic [2:0]        rs2_p0;
  logic [4:0]        imm_p0;
  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  logic [DATA_W-1:0] f_p0;
  logic [DATA_W-1:0] result_p1;

  assign opcode_p0 = instruction[15:11];
  assign rs1_p0    = instruction[10:8];
  assign rs2_p0    = instruction[7:5];
  assign imm_p0    = instruction[4:0];

  // Same-cycle write-back is forwarded so the operand never sees a stale value.
  always_comb begin
    op_a_p0 = regs[rs1_p0];
    op_b_p0 = regs[rs2_p0];
    if (write_en && (write_addr == rs1_p0)) op_a_p0 = write_data;
    if (write_en && (write_addr == rs2_p0)) op_b_p0 = write_data;
  end

  assign f_p0 = alu(opcode_p0, op_a_p0, op_b_p0, imm_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end

  // ---- stage boundary p0 -> p1 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) result_p1 <= '0;
    else       result_p1 <= f_p0;
  end

  assign result = result_p1;

endmodule

// File: tb/tb_decoding_stage.sv
// Directed bench for decoding_stage: hand-computed results checked one cycle
// after each instruction, including bypass, wrap, shift and async reset cases.
module tb_decoding_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [15:0] instruction;
  logic        write_en;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  decoding_stage dut (
    .clk         (clk),
    .reset       (reset),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .instruction (instruction),
    .write_en    (write_en),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Present one instruction (and optional write) for one edge, then settle.
  task automatic cyc(input logic [15:0] instr, input logic we,
                     input logic [2:0] wa, input logic [15:0] wd);
    instruction = instr;
    write_en    = we;
    write_addr  = wa;
    write_data  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [15:0] instr, input logic [15:0] exp);
    cyc(instr, 1'b0, 3'd0, 16'h0000);
    check(tag, result, exp);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [15:0] wd);
    cyc(16'h0000, 1'b1, wa, wd);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 16'h0000;
    write_en    = 1'b0;
    write_addr  = 3'd0;
    write_data  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 16'h0000);
    #3 reset = 1'b0;

    run("shl_r5_empty", 16'h65BF, 16'h0000);
    run("mov_r5_empty", 16'h25BF, 16'h0000);

    wr(3'd5, 16'h0001);
    check("nop_with_write", result, 16'h0000);
    run("shl_r5_by15", 16'h65BF, 16'h8000);
    run("mov_r5", 16'h25BF, 16'h0001);

    wr(3'd1, 16'h7FFF);
    wr(3'd2, 16'h0001);
    run("add_r1_r2", 16'h2940, 16'h8000);
    run("sub_r1_r2", 16'h3140, 16'h7FFE);
    run("sub_r2_r1_wrap", 16'h3220, 16'h8002);
    run("and_r1_r2", 16'h3940, 16'h0001);
    run("or_r1_r2", 16'h4140, 16'h7FFF);
    run("xor_r1_r2", 16'h4940, 16'h7FFE);
    run("dec_r2", 16'h1A00, 16'h0000);
    run("dec_r0_wrap", 16'h1800, 16'hFFFF);

    cyc(16'h2300, 1'b1, 3'd3, 16'h00F0);
    check("bypass_a_mov_r3", result, 16'h00F0);
    run("mov_r3_later", 16'h2300, 16'h00F0);
    cyc(16'h2B60, 1'b1, 3'd3, 16'h0010);
    check("bypass_ab_add_r3_r3", result, 16'h0020);
    run("add_r3_r3_later", 16'h2B60, 16'h0020);

    wr(3'd0, 16'h1234);
    run("mov_r0_written", 16'h2000, 16'h1234);

    wr(3'd4, 16'hFFFF);
    run("inc_r4_wrap", 16'h1400, 16'h0000);
    run("shr_r4_by4", 16'h6C04, 16'h0FFF);
    run("not_r4", 16'h0C00, 16'h0000);
    run("ldi_1f", 16'h701F, 16'h001F);
    run("shl_r2_imm4_ignored", 16'h6210, 16'h0001);

    run("shl_before_reset", 16'h65BF, 16'h8000);
    #2 reset = 1'b1;
    #1;
    check("async_reset_result", result, 16'h0000);
    #1 reset = 1'b0;
    run("mov_r5_after_reset", 16'h25BF, 16'h0000);
    run("mov_r1_after_reset", 16'h2100, 16'h0000);
    run("mov_r4_after_reset", 16'h2400, 16'h0000);
    run("mov_r0_after_reset", 16'h2000, 16'h0000);

    run("ldi_before_unused", 16'h701F, 16'h001F);
    run("unused_7800", 16'h7800, 16'h0000);
    run("ldi_before_unused2", 16'h7005, 16'h0005);
    run("unused_5000", 16'h5000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
